cordic_sincos_iter: RTL
=======================

Name: cordic_sincos_iter

Overview:
- Parametrised, handshaked successor to the fixed 7-stage cosine pipeline.
- Folds the full input circle and returns sin and cos together.
- Gain is pre-compensated, so no output multiplier is needed.
- Iterative: one rotation per clock, one job in flight. Used where area matters more than throughput.

Parameters:
- WIDTH, 16, phase and output word width (12..30).
- ITER, 14, CORDIC micro-rotations per job (4..WIDTH).
- GUARD, 2, extra LSBs carried internally on x, y and z.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous active-high reset
- in_valid  in  1  phase word valid
- in_ready  out  1  block can accept a phase word
- in_phase  in  WIDTH  unsigned binary angle; angle = in_phase*2*pi/2^WIDTH
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out_cos  out  WIDTH  signed cos, scale 2^(WIDTH-2)
- out_sin  out  WIDTH  signed sin, scale 2^(WIDTH-2)
- busy  out  1  high in ROT or DONE

Behaviour:
- Reset (async, rst=1): state=IDLE, in_ready=1, out_valid=0, out_cos=0, out_sin=0, busy=0, iteration counter=0.
- FSM IDLE -> ROT -> DONE -> IDLE.
- Handshake: in_ready = (state==IDLE). in_phase is sampled only on an edge where in_valid&in_ready.
- On acceptance, IDLE->ROT:
  - q = in_phase[WIDTH-1:WIDTH-2].
  - z = in_phase[WIDTH-3:0] zero-extended, then left-shifted by GUARD.
  - x = round(0.6072529350 * 2^(WIDTH-2+GUARD)).
  - y = 0, i = 0.
- ROT, one micro-rotation per edge:
  - d = (z >= 0) ? +1 : -1.
  - x' = x - d*(y>>>i); y' = y + d*(x>>>i); z' = z - d*ATAN[i]; i++.
  - Shifts are arithmetic.
  - Internal x/y width is WIDTH+GUARD+1 signed; z width is WIDTH+GUARD signed.
- ATAN[i] = round(atan(2^-i)/(2*pi) * 2^(WIDTH+GUARD)). It is a constant table fixed at elaboration; no runtime load.
- On the edge where i reaches ITER-1 and that rotation completes, ROT->DONE. On the same edge, outputs are registered after quadrant unfold:
  - q=0: cos=x, sin=y
  - q=1: cos=-y, sin=x
  - q=2: cos=-x, sin=-y
  - q=3: cos=y, sin=-x
- Output conversion: drop GUARD LSBs with round-half-up, then saturate to [-(2^(WIDTH-1)-1), 2^(WIDTH-1)-1].
- Latency: out_valid rises exactly ITER edges after the acceptance edge.
- DONE: out_valid=1; out_cos/out_sin held stable until out_valid&out_ready. On that edge go DONE->IDLE and clear out_valid.
  - in_ready stays 0 throughout DONE, so the minimum initiation interval is ITER+2 cycles.
- Backpressure: out_ready=0 holds DONE indefinitely with no output change. in_valid is ignored while not IDLE; the source must hold its word.
- out_ready while not in DONE is ignored.
- Phase wrap: in_phase=2^WIDTH-1 is angle just below 2*pi (q=3, residual near pi/2). CORDIC convergence covers ±1.74 rad, so the residual range [0, pi/2) is always within range.
- Reset mid-ROT or mid-DONE aborts the job immediately. No partial result is emitted. The first post-reset acceptance behaves as from power-up.
- Accuracy requirement: |error| <= 4 LSB on both outputs for ITER >= WIDTH-2.

Test Plan:
All scenarios use WIDTH=16, ITER=14, GUARD=2; scale is 16384.
1. Phase 0x0000, out_ready=1 -> out_valid 14 edges after acceptance; cos=16384±4, sin=0±4; in_ready back to 1 one cycle later.
2. Phases 0x2000/0x4000/0x8000/0xC000 in turn ->
   - 0x2000: (11585, 11585)
   - 0x4000: (0, 16384)
   - 0x8000: (-16384, 0)
   - 0xC000: (0, -16384)
   - all ±4 LSB.
3. Phase 0xFFFF and 0x5555 -> cos/sin within ±4 LSB of round(16384*cos/sin(2*pi*p/65536)); no saturation artefacts or sign flips.
4. out_ready=0 for 20 cycles after out_valid -> outputs and out_valid stable, in_ready=0, busy=1; in_valid pulses ignored. out_ready=1 -> exactly one transfer, then IDLE.
5. rst asserted at ROT iteration 5, then phase 0x4000 issued -> out_valid, outputs and busy go 0 asynchronously with no stale result; the next job yields (0, 16384)±4 at the nominal latency.
6. 200 random phases with random in_valid/out_ready gaps -> results in order, one per accepted phase, all within ±4 LSB of the reference model.

Source files
------------

// File: rtl/cordic_sincos_iter_if.sv
// Phase-in / sin-cos-out handshake bundle for cordic_sincos_iter.
// The slave modport is the CORDIC core; the master modport is its user.
interface cordic_sincos_iter_if #(
  parameter int unsigned WIDTH = 16
) ();
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_phase;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_cos;
  logic [WIDTH-1:0] out_sin;

  modport slave (
    input  in_valid, in_phase, out_ready,
    output in_ready, out_valid, out_cos, out_sin
  );

  modport master (
    output in_valid, in_phase, out_ready,
    input  in_ready, out_valid, out_cos, out_sin
  );
endinterface

// File: rtl/cordic_sincos_iter.sv
// Iterative CORDIC sin/cos: one micro-rotation per clock, one job in flight.
// Full-circle input is folded to the first quadrant and unfolded on the way out.
module cordic_sincos_iter #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned ITER  = 14,
  parameter int unsigned GUARD = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  cordic_sincos_iter_if.slave  bus,
  output logic                 busy
);
  localparam int unsigned XW = WIDTH + GUARD + 1;
  localparam int unsigned ZW = WIDTH + GUARD;
  localparam int unsigned CW = $clog2(ITER);
  localparam real         PI = 3.14159265358979323846;
  localparam real         KGAIN = 0.6072529350;

  localparam logic signed [XW-1:0] X_INIT =
    XW'($rtoi(KGAIN * (2.0 ** (WIDTH - 2 + GUARD)) + 0.5));
  localparam int                   RND_I = (GUARD > 0) ? (1 << (GUARD - 1)) : 0;
  localparam int                   MAX_I = (1 << (WIDTH - 1)) - 1;
  localparam logic signed [XW+1:0] RND = (XW + 2)'(RND_I);
  localparam logic signed [XW+1:0] SAT_HI = (XW + 2)'(MAX_I);
  localparam logic signed [XW+1:0] SAT_LO = -SAT_HI;
  localparam logic [CW-1:0]        LAST = CW'(ITER - 1);

  // atan(2^-i) in turns scaled to 2^ZW; small angles use a two-term series.
  function automatic int unsigned atan_fix(input int unsigned i);
    real a;
    real t;
    t = 1.0;
    for (int unsigned k = 0; k < i; k++) t = t / 2.0;
    case (i)
      0:       a = 0.78539816339744831;
      1:       a = 0.46364760900080612;
      2:       a = 0.24497866312686414;
      3:       a = 0.12435499454676144;
      4:       a = 0.06241880999595735;
      5:       a = 0.031239833430268277;
      6:       a = 0.015623728620476831;
      7:       a = 0.0078123410601011113;
      8:       a = 0.0039062301319669718;
      9:       a = 0.0019531225164788188;
      10:      a = 0.00097656218955931943;
      11:      a = 0.00048828121119489829;
      12:      a = 0.00024414062014936177;
      13:      a = 0.00012207031189367021;
      14:      a = 6.1035156174208773e-05;
      15:      a = 3.0517578115526096e-05;
      default: a = t - t * t * t / 3.0;
    endcase
    return $rtoi(a / (2.0 * PI) * (2.0 ** ZW) + 0.5);
  endfunction

  logic [ZW-1:0] atan_lut [ITER];
  for (genvar g = 0; g < ITER; g++) begin : g_atan
    localparam int unsigned AV = atan_fix(g);
    assign atan_lut[g] = AV[ZW-1:0];
  end

  // Round half up, drop guard bits, clamp symmetrically.
  function automatic logic [WIDTH-1:0] to_out(input logic signed [XW:0] v);
    logic signed [XW+1:0] r;
    r = {v[XW], v} + RND;
    r = r >>> GUARD;
    if (r > SAT_HI)      r = SAT_HI;
    else if (r < SAT_LO) r = SAT_LO;
    return r[WIDTH-1:0];
  endfunction

  typedef enum logic [1:0] {StIdle, StRot, StDone} state_e;

  state_e               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic signed [XW-1:0] x_q, x_d, y_q, y_d;
  logic signed [ZW-1:0] z_q, z_d;
  logic [1:0]           q_q, q_d;
  logic [WIDTH-1:0]     cos_q, cos_d, sin_q, sin_d;

  logic signed [XW-1:0] x_sh, y_sh, x_rot, y_rot;
  logic signed [ZW-1:0] z_rot;
  logic signed [XW:0]   u_cos, u_sin;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      q_q     <= '0;
      cos_q   <= '0;
      sin_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      x_q     <= x_d;
      y_q     <= y_d;
      z_q     <= z_d;
      q_q     <= q_d;
      cos_q   <= cos_d;
      sin_q   <= sin_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    x_d     = x_q;
    y_d     = y_q;
    z_d     = z_q;
    q_d     = q_q;
    cos_d   = cos_q;
    sin_d   = sin_q;

    x_sh = x_q >>> cnt_q;
    y_sh = y_q >>> cnt_q;
    if (!z_q[ZW-1]) begin
      x_rot = x_q - y_sh;
      y_rot = y_q + x_sh;
      z_rot = z_q - $signed(atan_lut[cnt_q]);
    end else begin
      x_rot = x_q + y_sh;
      y_rot = y_q - x_sh;
      z_rot = z_q + $signed(atan_lut[cnt_q]);
    end

    // Unfold from the just-completed rotation so the result lands on the final edge.
    u_cos = '0;
    u_sin = '0;
    unique case (q_q)
      2'd0: begin u_cos =  {x_rot[XW-1], x_rot}; u_sin =  {y_rot[XW-1], y_rot}; end
      2'd1: begin u_cos = -{y_rot[XW-1], y_rot}; u_sin =  {x_rot[XW-1], x_rot}; end
      2'd2: begin u_cos = -{x_rot[XW-1], x_rot}; u_sin = -{y_rot[XW-1], y_rot}; end
      2'd3: begin u_cos =  {y_rot[XW-1], y_rot}; u_sin = -{x_rot[XW-1], x_rot}; end
      default: ;
    endcase

    unique case (state_q)
      StIdle: begin
        if (bus.in_valid) begin
          state_d = StRot;
          cnt_d   = '0;
          x_d     = X_INIT;
          y_d     = '0;
          z_d     = $signed(ZW'(bus.in_phase[WIDTH-3:0]) << GUARD);
          q_d     = bus.in_phase[WIDTH-1 -: 2];
        end
      end
      StRot: begin
        x_d   = x_rot;
        y_d   = y_rot;
        z_d   = z_rot;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          state_d = StDone;
          cnt_d   = '0;
          cos_d   = to_out(u_cos);
          sin_d   = to_out(u_sin);
        end
      end
      StDone: begin
        if (bus.out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign bus.in_ready  = (state_q == StIdle);
  assign bus.out_valid = (state_q == StDone);
  assign bus.out_cos   = cos_q;
  assign bus.out_sin   = sin_q;
  assign busy          = (state_q != StIdle);

endmodule
